mem_burst_responder: RTL and testbench

//  Responder end of the IMEM/DMEM access protocol (address/data_in/access_size/rw/enable -> data_out/busy).

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_burst_ctr.sv | 39 +++
 rtl/mem_burst_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_burst_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the IMEM/DMEM burst responder: access-size and
// FSM state encodings plus the access-size to beat-count decode.
package mem_pkg;

    typedef enum logic [1:0] {
        ASZ_1W  = 2'b00,
        ASZ_4W  = 2'b01,
        ASZ_8W  = 2'b10,
        ASZ_16W = 2'b11
    } asz_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RWAIT  = 2'b01,
        S_RBURST = 2'b10,
        S_WBURST = 2'b11
    } state_e;

    // Number of words moved by one request of the given access size.
    function automatic logic [4:0] beats(input logic [1:0] access_size);
        case (asz_e'(access_size))
            ASZ_1W:  return 5'd1;
            ASZ_4W:  return 5'd4;
            ASZ_8W:  return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_burst_ctr.sv
// Beat counter and wrapping word-address generator for one burst.
// The word address is WW bits wide, so incrementing past the top of the
// array wraps back to word 0 by plain overflow.
module mem_burst_ctr #(
    parameter int unsigned WW = 18
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic          inc,
    input  logic [WW-1:0] load_word,
    input  logic [4:0]    load_beat,
    input  logic [4:0]    load_len,
    output logic [WW-1:0] word,
    output logic          last
);

    logic [4:0] beat;
    logic [4:0] len;

    // Load starts a burst at a given word/beat; inc advances to the next beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word <= '0;
            beat <= '0;
            len  <= '0;
        end else if (load) begin
            word <= load_word;
            beat <= load_beat;
            len  <= load_len;
        end else if (inc) begin
            word <= word + 1'b1;
            beat <= beat + 5'd1;
        end
    end

    assign last = (beat == len - 5'd1);

endmodule

// File: rtl/mem_burst_responder.sv
// Responder end of the IMEM/DMEM access protocol. Serves single-word and
// 4/8/16-word bursts from a big-endian byte array with programmable read
// latency. Optional feature macro: MEM_RESP_ERR_EN adds the err port,
// flags out-of-range requests, suppresses their writes and zeroes their reads.
module mem_burst_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8002_0000,
    parameter int unsigned MEMORY_DEPTH = 1048576,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] address,
    input  logic [1:0]  access_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        busy
`ifdef MEM_RESP_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned AW = $clog2(MEMORY_DEPTH);
    localparam int unsigned WW = AW - 2;

    state_e          state, state_nx;
    logic [2:0]      lat_cnt;
    logic            req_bad;

    logic [WW-1:0]   acc_word;
    logic            acc_bad;
    logic            accept;

    logic            ctr_load, ctr_inc, ctr_last;
    logic [WW-1:0]   ctr_word, ld_word;
    logic [4:0]      ld_beat;

    logic            wr_en, wr_bad, rd_fire;
    logic [WW-1:0]   wr_word;
    logic [31:0]     rd_word;

    logic [7:0]      mem [MEMORY_DEPTH];

    // Word index of the request, taken modulo the array size.
    assign acc_word = WW'((address - BASE_ADDR) >> 2);
    assign accept   = (state == S_IDLE) && enable;

`ifdef MEM_RESP_ERR_EN
    // Below BASE_ADDR the subtraction wraps to a huge offset, so one compare
    // covers both ends of the window.
    assign acc_bad = (address - BASE_ADDR) >= 32'(MEMORY_DEPTH);
`else
    assign acc_bad = 1'b0;
`endif

    mem_burst_ctr #(
        .WW(WW)
    ) u_ctr (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (ctr_load),
        .inc       (ctr_inc),
        .load_word (ld_word),
        .load_beat (ld_beat),
        .load_len  (beats(access_size)),
        .word      (ctr_word),
        .last      (ctr_last)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state decode and per-cycle burst controls.
    always_comb begin
        state_nx = state;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        ld_word  = acc_word;
        ld_beat  = '0;
        wr_en    = 1'b0;
        wr_word  = ctr_word;
        wr_bad   = req_bad;
        rd_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    if (rw) begin
                        state_nx = S_RWAIT;
                        ctr_load = 1'b1;
                    end else begin
                        // Beat 0 is written straight from the request; the
                        // counter starts at beat 1 for the remainder.
                        wr_en   = 1'b1;
                        wr_word = acc_word;
                        wr_bad  = acc_bad;
                        if (beats(access_size) != 5'd1) begin
                            state_nx = S_WBURST;
                            ctr_load = 1'b1;
                            ld_word  = acc_word + 1'b1;
                            ld_beat  = 5'd1;
                        end
                    end
                end
            end
            S_RWAIT: begin
                if (lat_cnt == 3'd0) begin
                    rd_fire  = 1'b1;
                    ctr_inc  = 1'b1;
                    state_nx = ctr_last ? S_IDLE : S_RBURST;
                end
            end
            S_RBURST: begin
                rd_fire = 1'b1;
                ctr_inc = 1'b1;
                if (ctr_last) state_nx = S_IDLE;
            end
            S_WBURST: begin
                wr_en   = 1'b1;
                ctr_inc = 1'b1;
                if (ctr_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Read-latency countdown and out-of-range flag captured at accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= '0;
            req_bad <= 1'b0;
        end else begin
            if (accept) begin
                lat_cnt <= 3'(READ_LATENCY);
                req_bad <= acc_bad;
            end else if (state == S_RWAIT && lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end

    assign rd_word = {mem[{ctr_word, 2'b00}], mem[{ctr_word, 2'b01}],
                      mem[{ctr_word, 2'b10}], mem[{ctr_word, 2'b11}]};

    // Registered read beats; data_out holds its last beat between bursts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_fire;
            if (rd_fire) data_out <= req_bad ? '0 : rd_word;
        end
    end

    // Byte array write port, big-endian; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en && reset_n && !wr_bad) begin
            mem[{wr_word, 2'b00}] <= data_in[31:24];
            mem[{wr_word, 2'b01}] <= data_in[23:16];
            mem[{wr_word, 2'b10}] <= data_in[15:8];
            mem[{wr_word, 2'b11}] <= data_in[7:0];
        end
    end

`ifdef MEM_RESP_ERR_EN
    logic err_arm;

    // err is a one-cycle pulse one cycle after an out-of-range accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_arm <= 1'b0;
            err     <= 1'b0;
        end else begin
            err_arm <= accept && acc_bad;
            err     <= err_arm;
        end
    end
`endif

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_burst_responder.sv
// Testbench for mem_burst_responder: two instances (read latency 0 and 3)
// share one stimulus stream and are compared against a transaction-level
// byte-array model. Honours MEM_RESP_ERR_EN when defined.
module tb_mem_burst_responder;

    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam int unsigned DEPTH = 4096;
`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n, enable, rw;
    logic [31:0] address, data_in;
    logic [1:0]  access_size;
    logic [31:0] dout0, dout3;
    logic        dv0, dv3, busy0, busy3;
`ifdef MEM_RESP_ERR_EN
    logic        err0, err3;
`endif

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] exp_dout [2];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clock = ~clock;

    mem_burst_responder #(
        .BASE_ADDR(BASE), .MEMORY_DEPTH(DEPTH), .READ_LATENCY(0)
    ) u_dut_l0 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .rw(rw),
        .address(address), .access_size(access_size), .data_in(data_in),
        .data_out(dout0), .data_valid(dv0), .busy(busy0)
`ifdef MEM_RESP_ERR_EN
        , .err(err0)
`endif
    );

    mem_burst_responder #(
        .BASE_ADDR(BASE), .MEMORY_DEPTH(DEPTH), .READ_LATENCY(3)
    ) u_dut_l3 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .rw(rw),
        .address(address), .access_size(access_size), .data_in(data_in),
        .data_out(dout3), .data_valid(dv3), .busy(busy3)
`ifdef MEM_RESP_ERR_EN
        , .err(err3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a - BASE) < DEPTH;
    endfunction

    function automatic int unsigned byte_idx(input logic [31:0] a, input int k);
        logic [31:0] off;
        off = ((a - BASE) & ~32'd3) + 32'(4 * k);
        return off % DEPTH;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int k);
        int unsigned i;
        i = byte_idx(a, k);
        return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd [16]);
        int n;
        bit bad;
        int unsigned i;
        int last_j;
        n = beats_of(sz);
        bad = ERR_EN && !in_range(addr);
        last_j = (n > 2) ? n : 2;
        @(negedge clock);
        enable = 1'b1; rw = 1'b0; address = addr; access_size = sz; data_in = wd[0];
        for (int j = 0; j <= last_j; j++) begin
            if (j > 0) begin
                @(negedge clock);
                if (j < n) begin
                    enable = 1'($urandom); rw = 1'($urandom);
                    address = $urandom; access_size = 2'($urandom);
                    data_in = wd[j];
                end else begin
                    enable = 1'b0;
                    data_in = $urandom;
                end
            end
            @(posedge clock); #1;
            if (j < n && !bad) begin
                i = byte_idx(addr, j);
                {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]} = wd[j];
            end
            check("wr_busy_l0", busy0, (j < n - 1));
            check("wr_busy_l3", busy3, (j < n - 1));
            check("wr_valid_l0", dv0, 0);
            check("wr_valid_l3", dv3, 0);
            check("wr_dout_l0", dout0, exp_dout[0]);
            check("wr_dout_l3", dout3, exp_dout[1]);
`ifdef MEM_RESP_ERR_EN
            check("wr_err_l0", err0, (j == 1) && bad);
            check("wr_err_l3", err3, (j == 1) && bad);
`endif
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] sz, input bit hold);
        int n;
        bit bad;
        int lat;
        bit v;
        logic [31:0] beat_val [16];
        n = beats_of(sz);
        bad = ERR_EN && !in_range(addr);
        for (int k = 0; k < 16; k++) beat_val[k] = bad ? 32'h0 : ref_word(addr, k);
        @(negedge clock);
        enable = 1'b1; rw = 1'b1; address = addr; access_size = sz; data_in = $urandom;
        for (int j = 0; j <= n + 3; j++) begin
            if (j > 0) begin
                @(negedge clock);
                if (hold && j <= n) begin
                    enable = 1'b1; rw = 1'($urandom);
                    address = $urandom; access_size = 2'($urandom);
                end else begin
                    enable = 1'b0;
                end
                data_in = $urandom;
            end
            @(posedge clock); #1;
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 0 : 3;
                v = (j >= lat + 1) && (j <= lat + n);
                if (v) exp_dout[d] = beat_val[j - lat - 1];
                check($sformatf("rd_valid_l%0d", lat), (d == 0) ? dv0 : dv3, v);
                check($sformatf("rd_busy_l%0d", lat), (d == 0) ? busy0 : busy3, (j <= lat + n - 1));
                check($sformatf("rd_dout_l%0d", lat), (d == 0) ? dout0 : dout3, exp_dout[d]);
            end
`ifdef MEM_RESP_ERR_EN
            check("rd_err_l0", err0, (j == 1) && bad);
            check("rd_err_l3", err3, (j == 1) && bad);
`endif
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy_l0"}, busy0, 0);
        check({tag, "_busy_l3"}, busy3, 0);
        check({tag, "_valid_l0"}, dv0, 0);
        check({tag, "_valid_l3"}, dv3, 0);
        check({tag, "_dout_l0"}, dout0, 0);
        check({tag, "_dout_l3"}, dout3, 0);
`ifdef MEM_RESP_ERR_EN
        check({tag, "_err_l0"}, err0, 0);
        check({tag, "_err_l3"}, err3, 0);
`endif
        exp_dout[0] = '0;
        exp_dout[1] = '0;
    endtask

    task automatic reset_mid_read();
        @(negedge clock);
        enable = 1'b1; rw = 1'b1; address = BASE + 32'h100; access_size = 2'b11;
        @(negedge clock);
        enable = 1'b0;
        repeat (5) @(negedge clock);
        check("mid_busy_l0", busy0, 1);
        check("mid_busy_l3", busy3, 1);
        check("mid_valid_l0", dv0, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] wd [16];
        logic [31:0] a;

        reset_n = 1'b0; enable = 1'b0; rw = 1'b0;
        address = '0; access_size = '0; data_in = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Fill the whole array so every later read has defined contents.
        for (int b = 0; b < int'(DEPTH / 64); b++) begin
            for (int k = 0; k < 16; k++) wd[k] = $urandom;
            do_write(BASE + 32'(b * 64), 2'b11, wd);
        end

        // Reset mid 16-word read, then a plain single read.
        reset_mid_read();
        do_read(BASE, 2'b00, 1'b0);

        // Single-word write then read, with byte-order check.
        for (int k = 0; k < 16; k++) wd[k] = '0;
        wd[0] = 32'h1234_5678;
        do_write(BASE, 2'b00, wd);
        check("mem_byte0", u_dut_l0.mem[0], 8'h12);
        check("mem_byte1", u_dut_l0.mem[1], 8'h34);
        check("mem_byte2", u_dut_l0.mem[2], 8'h56);
        check("mem_byte3", u_dut_l0.mem[3], 8'h78);
        do_read(BASE, 2'b00, 1'b0);
        check("rd_single_value", dout0, 32'h1234_5678);

        // 4-word write of A0..A3 and 4-word read back.
        for (int k = 0; k < 4; k++) wd[k] = 32'hA0 + 32'(k);
        do_write(BASE + 32'h10, 2'b01, wd);
        do_read(BASE + 32'h10, 2'b01, 1'b0);
        check("rd_burst4_last", dout3, 32'hA3);

        // Wrap past the top of the array on both write and read.
        for (int k = 0; k < 16; k++) wd[k] = $urandom;
        do_write(BASE + DEPTH - 12, 2'b10, wd);
        do_read(BASE + DEPTH - 8, 2'b10, 1'b0);

        // Unaligned address and enable held high through the burst.
        do_read(32'h8002_0006, 2'b01, 1'b1);
        do_read(32'h8002_0006, 2'b11, 1'b1);

        // Address far below the window, then confirm what mem[0] holds.
        wd[0] = 32'hDEAD_BEEF;
        do_write(32'h0000_0000, 2'b00, wd);
        do_read(32'h0000_0000, 2'b00, 1'b0);
        do_read(BASE, 2'b00, 1'b0);

        // Random mix of reads and writes, mostly in range.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 4) == 0) a = $urandom;
            else a = BASE + $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 16; k++) wd[k] = $urandom;
                do_write(a, 2'($urandom), wd);
            end else begin
                do_read(a, 2'($urandom), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
